vga_fb_fill: RTL and testbench

- Pixel source that sits directly upstream of the VGA timing controller and drives its 12-bit pixel input (bbbb_gggg_rrrr) from the controller's registered row/column address.
- Holds an 80x60 low-resolution framebuffer; each stored pixel is shown as an 8x8 block on the 640x480 screen.
- Game logic draws through a command port: a solid-colour rectangle fill engine, optionally synchronised to vertical sync.
- Clears itself to black after every reset.

---
 rtl/vga_fb_fill.sv | 171 +++++++++++++++++
 tb/tb_vga_fb_fill.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_fill.sv
// 80x60 12-bit framebuffer shown as 8x8 blocks on a 640x480 raster, with a
// rectangle fill engine (optionally vsync-aligned) that self-clears after reset.
module vga_fb_fill #(
  parameter int FB_W     = 80,
  parameter int FB_H     = 60,
  parameter int SCALE_SH = 3
) (
  input  logic        vga_clk,
  input  logic        clr,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        vs,
  output logic [11:0] d_out,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_x0,
  input  logic [6:0]  cmd_x1,
  input  logic [5:0]  cmd_y0,
  input  logic [5:0]  cmd_y1,
  input  logic [11:0] cmd_color,
  input  logic        cmd_wait_vs,
  output logic        busy,
  output logic        done
);

  localparam int              FB_N      = FB_W * FB_H;
  localparam logic [6:0]      X_MAX     = 7'(FB_W - 1);
  localparam logic [5:0]      Y_MAX     = 6'(FB_H - 1);
  localparam logic [12:0]     LAST_ADDR = 13'(FB_N - 1);
  localparam logic [9:0]      COL_LIM   = 10'(FB_W << SCALE_SH);
  localparam logic [8:0]      ROW_LIM   = 9'(FB_H << SCALE_SH);

  // state     | meaning
  // S_CLEAR   | writing black to every word, pointer 0..FB_N-1
  // S_IDLE    | ready for a command
  // S_WAIT_VS | command latched, waiting for a falling edge of vs
  // S_FILL    | writing one pixel of the rectangle per cycle
  // S_EMPTY   | command covered no pixels
  // S_DONE    | one-cycle completion pulse, accepts a new command
  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_WAIT_VS, S_FILL, S_EMPTY, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] clr_ptr_q;
  logic [6:0]  x_q, x0_q, x1_q;
  logic [5:0]  y_q, y1_q;
  logic [11:0] color_q;
  logic        vs_q;

  logic [11:0] mem [0:FB_N-1];

  logic        wr_en;
  logic [12:0] wr_addr;
  logic [11:0] wr_data;
  logic        accept;
  logic [6:0]  x1_clip;
  logic [5:0]  y1_clip;
  logic        cmd_empty;
  logic        last_px;

  // The shift-add below is y*80; it tracks FB_W only for the default width.
  function automatic logic [12:0] lin_addr(input logic [5:0] y, input logic [6:0] x);
    return ({7'd0, y} << 6) + ({7'd0, y} << 4) + {6'd0, x};
  endfunction

  logic [5:0]  rd_y;
  logic [6:0]  rd_x;
  logic [12:0] rd_addr;
  logic        visible;

  assign rd_y    = row_addr[8:SCALE_SH];
  assign rd_x    = col_addr[9:SCALE_SH];
  assign rd_addr = lin_addr(rd_y, rd_x);
  assign visible = (col_addr < COL_LIM) && (row_addr < ROW_LIM);
  assign d_out   = visible ? mem[rd_addr] : 12'h000;

  assign x1_clip   = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
  assign y1_clip   = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
  assign cmd_empty = (cmd_x0 > x1_clip) || (cmd_y0 > y1_clip) ||
                     (cmd_x0 > X_MAX)   || (cmd_y0 > Y_MAX);
  assign last_px   = (x_q == x1_q) && (y_q == y1_q);

  always_ff @(posedge vga_clk) begin
    if (clr) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      vs_q      <= 1'b1;
    end else begin
      state_q <= state_d;
      vs_q    <= vs;
      if (state_q == S_CLEAR) clr_ptr_q <= clr_ptr_q + 13'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    wr_addr   = lin_addr(y_q, x_q);
    wr_data   = color_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_ptr_q;
        wr_data = 12'h000;
        if (clr_ptr_q == LAST_ADDR) state_d = S_IDLE;
      end
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        accept    = cmd_valid;
      end
      S_WAIT_VS: begin
        if (vs_q && !vs) state_d = S_FILL;
      end
      S_FILL: begin
        wr_en = 1'b1;
        if (last_px) state_d = S_DONE;
      end
      S_EMPTY: state_d = S_DONE;
      S_DONE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        done      = 1'b1;
        accept    = cmd_valid;
        state_d   = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
    if (accept) begin
      if (cmd_empty)        state_d = S_EMPTY;
      else if (cmd_wait_vs) state_d = S_WAIT_VS;
      else                  state_d = S_FILL;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (clr) begin
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else if (accept) begin
      x_q     <= cmd_x0;
      y_q     <= cmd_y0;
      x0_q    <= cmd_x0;
      x1_q    <= x1_clip;
      y1_q    <= y1_clip;
      color_q <= cmd_color;
    end else if (state_q == S_FILL && !last_px) begin
      // Hold on the final pixel so counters stay inside the clipped bounds.
      if (x_q == x1_q) begin
        x_q <= x0_q;
        y_q <= y_q + 6'd1;
      end else begin
        x_q <= x_q + 7'd1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (wr_en && !clr) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_vga_fb_fill.sv
// Scoreboard bench for vga_fb_fill: expected done cycles, ready-rise cycles and
// pixel values are queued by the stimulus and checked by a negedge monitor.
module tb_vga_fb_fill;

  logic        vga_clk = 1'b0;
  logic        clr = 1'b1;
  logic [8:0]  row_addr = '0;
  logic [9:0]  col_addr = '0;
  logic        vs = 1'b1;
  logic [11:0] d_out;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_x0 = '0, cmd_x1 = '0;
  logic [5:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [11:0] cmd_color = '0;
  logic        cmd_wait_vs = 1'b0;
  logic        busy, done;

  vga_fb_fill dut (
    .vga_clk(vga_clk), .clr(clr), .row_addr(row_addr), .col_addr(col_addr),
    .vs(vs), .d_out(d_out), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .cmd_wait_vs(cmd_wait_vs), .busy(busy), .done(done)
  );

  always #20 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_q[$];
  int          ready_q[$];
  logic [11:0] pix_q[$];
  bit          pix_chk = 1'b0;
  bit          ready_prev = 1'b0;
  logic [11:0] ref_fb[4800];
  int          mon_e;
  logic [11:0] mon_p;

  function automatic logic [11:0] exp_pix(input int r, input int c);
    if (c >= 640 || r >= 480) return 12'h000;
    return ref_fb[(r / 8) * 80 + (c / 8)];
  endfunction

  always @(negedge vga_clk) begin
    if (done) begin
      n_cmp++;
      if (done_q.size() == 0) begin
        n_bad++;
        $display("FAIL done_pulse: got done at cycle %0d, expected no done", cyc);
      end else begin
        mon_e = done_q.pop_front();
        if (mon_e != cyc) begin
          n_bad++;
          $display("FAIL done_cycle: got cycle %0d, expected cycle %0d", cyc, mon_e);
        end
      end
    end
    if (pix_chk && pix_q.size() > 0) begin
      mon_p = pix_q.pop_front();
      n_cmp++;
      if (d_out !== mon_p) begin
        n_bad++;
        $display("FAIL pixel r=%0d c=%0d: got %03h, expected %03h", row_addr, col_addr, d_out, mon_p);
      end
    end
    if (cmd_ready && !ready_prev && ready_q.size() > 0) begin
      mon_e = ready_q.pop_front();
      n_cmp++;
      if (mon_e != cyc) begin
        n_bad++;
        $display("FAIL ready_rise: got cycle %0d, expected cycle %0d", cyc, mon_e);
      end
    end
    ready_prev = cmd_ready;
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check_point(input int r, input int c);
    row_addr = 9'(r);
    col_addr = 10'(c);
    pix_q.push_back(exp_pix(r, c));
    pix_chk = 1'b1;
    step();
    pix_chk = 1'b0;
  endtask

  task automatic scan_rect(input int r0, input int r1, input int c0, input int c1);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++)
        check_point(r, c);
  endtask

  task automatic scan_fb();
    for (int y = 0; y < 60; y++)
      for (int x = 0; x < 80; x++)
        check_point(y * 8 + int'($urandom_range(0, 7)), x * 8 + int'($urandom_range(0, 7)));
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((done_q.size() > 0 || ready_q.size() > 0 || busy) && b < 20000) begin
      step();
      b++;
    end
    if (b >= 20000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got done_q=%0d ready_q=%0d busy=%0b, expected 0 0 0",
               done_q.size(), ready_q.size(), busy);
      done_q.delete();
      ready_q.delete();
    end
    step();
  endtask

  task automatic do_reset(input int n);
    clr = 1'b1;
    repeat (n) step();
    clr = 1'b0;
    ready_q.push_back(cyc + 4800);
    foreach (ref_fb[i]) ref_fb[i] = 12'h000;
    wait_idle();
  endtask

  task automatic issue(input int x0, input int x1, input int y0, input int y1,
                       input logic [11:0] col, input bit wv, input int d);
    int  b, x1c, y1c, n;
    bit  empty;
    cmd_x0 = 7'(x0); cmd_x1 = 7'(x1); cmd_y0 = 6'(y0); cmd_y1 = 6'(y1);
    cmd_color = col; cmd_wait_vs = wv; cmd_valid = 1'b1;
    b = 0;
    while (!cmd_ready && b < 20000) begin
      step();
      b++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got cmd_ready=%0b, expected 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0;
    x1c   = (x1 > 79) ? 79 : x1;
    y1c   = (y1 > 59) ? 59 : y1;
    empty = (x0 > x1c) || (y0 > y1c) || (x0 > 79) || (y0 > 59);
    n     = empty ? 0 : (x1c - x0 + 1) * (y1c - y0 + 1);
    if (!empty)
      for (int yy = y0; yy <= y1c; yy++)
        for (int xx = x0; xx <= x1c; xx++)
          ref_fb[yy * 80 + xx] = col;
    if (empty) begin
      done_q.push_back(cyc + 1);
    end else if (!wv) begin
      done_q.push_back(cyc + n);
    end else begin
      if (vs == 1'b0) begin
        repeat (d) step();
        vs = 1'b1;
        step();
        step();
      end
      repeat (d) step();
      vs = 1'b0;
      done_q.push_back(cyc + 1 + n);
      step();
      vs = 1'b1;
    end
  endtask

  task automatic rand_issue(input bit allow_vs, input bit nonzero);
    int x0, x1, y0, y1;
    logic [11:0] col;
    bit wv;
    x0 = int'($urandom_range(0, 90));
    x1 = x0 + int'($urandom_range(0, 22)) - 2;
    if (x1 < 0) x1 = 0;
    if (x1 > 127) x1 = 127;
    if ($urandom_range(0, 7) == 0) x1 = int'($urandom_range(0, 127));
    y0 = int'($urandom_range(0, 63));
    y1 = y0 + int'($urandom_range(0, 11)) - 1;
    if (y1 < 0) y1 = 0;
    if (y1 > 63) y1 = 63;
    col = 12'($urandom);
    if (nonzero) col = col | 12'h001;
    wv = allow_vs && ($urandom_range(0, 3) == 0);
    issue(x0, x1, y0, y1, col, wv, int'($urandom_range(0, 4)));
  endtask

  initial begin
    do_reset(2);
    repeat (10) rand_issue(1'b0, 1'b1);
    wait_idle();
    do_reset(2);
    scan_fb();

    issue(5, 5, 7, 7, 12'hF00, 1'b0, 0);
    wait_idle();
    scan_rect(48, 71, 32, 55);

    issue(10, 12, 3, 4, 12'h0F0, 1'b0, 0);
    wait_idle();
    scan_rect(16, 47, 72, 111);

    issue(70, 127, 59, 59, 12'h00F, 1'b0, 0);
    issue(20, 10, 5, 6, 12'hFFF, 1'b0, 0);
    wait_idle();
    scan_rect(464, 479, 544, 639);
    scan_rect(40, 55, 72, 175);
    check_point(0, 640);
    check_point(100, 799);
    check_point(480, 0);
    check_point(524, 700);
    check_point(511, 1023);
    check_point(479, 639);

    issue(0, 3, 0, 1, 12'h123, 1'b1, 2);
    wait_idle();
    vs = 1'b0;
    step();
    step();
    issue(4, 6, 0, 0, 12'h456, 1'b1, 3);
    wait_idle();
    scan_rect(0, 15, 0, 63);

    repeat (30) rand_issue(1'b1, 1'b0);
    wait_idle();
    scan_fb();

    cmd_x0 = 7'd0; cmd_x1 = 7'd49; cmd_y0 = 6'd10; cmd_y1 = 6'd11;
    cmd_color = 12'hABC; cmd_wait_vs = 1'b0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    ready_q.push_back(cyc + 4800);
    foreach (ref_fb[i]) ref_fb[i] = 12'h000;
    wait_idle();
    scan_fb();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
